leaky_relu_act_sched: RTL and testbench
=======================================

// Module: leaky_relu_act_sched
// PURPOSE
//  Sequences one shared leaky-ReLU activation stage over one layer's neuron outputs.
//  Accepts a start command with a per-layer element count and alpha shift.
//  Streams that many signed SIZE-bit accumulator results in over valid/ready.
//  Emits 2*SIZE-bit activations with a last marker and a done pulse.
//  Sits between the layer MAC array and the next layer's input buffer.
// PARAMETERS
//  SIZE     8   input width, signed two's complement; output is 2*SIZE
//  CNT_W    10  width of element count (max layer = 2**CNT_W-1 elements)
//  SHIFT_W  4   width of cfg_shift; effective shift clamped to SIZE
// PORTS
//  clk        in   1         single clock, all logic on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  start      in   1         1-cycle command pulse; honoured only in IDLE
//  cfg_count  in   CNT_W     elements in this layer, sampled on start
//  cfg_shift  in   SHIFT_W   positive-side left shift (alpha = 2^-shift), sampled on start
//  abort      in   1         sync abort; returns to IDLE, no done
//  in_valid   in   1         input element valid
//  in_ready   out  1         block can accept input this cycle
//  in_data    in   SIZE      signed input element
//  out_valid  out  1         output register holds a result
//  out_ready  in   1         downstream accepts output
//  out_data   out  2*SIZE    activation result
//  out_last   out  1         qualifies out_data as final element of layer
//  busy       out  1         state != IDLE
//  done       out  1         1-cycle pulse after last output handshake
//  count      out  CNT_W     elements accepted so far in current layer
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=0, out_valid=0, out_data=0,
//   out_last=0, done=0, count=0, latched count/shift=0. Reset mid-layer drops all data.
//  States: IDLE -> RUN on start with cfg_count!=0 (latch cfg_count and min(cfg_shift,SIZE), count<=0).
//   IDLE + start with cfg_count==0: stay IDLE, done pulses the next cycle.
//   RUN -> DRAIN when the element with count==latched_count-1 is accepted.
//   DRAIN -> IDLE when out_valid&&out_ready&&out_last; done=1 the following cycle.
//   abort (any state) -> IDLE next cycle, out_valid=0, count=0, no done; abort beats start.
//  start while busy is ignored; the latched config is stable for the whole layer.
//  Handshake: in_ready = (state==RUN) && (!out_valid || out_ready); combinational from out_ready.
//   Accept = in_valid && in_ready. Data is held while out_valid && !out_ready.
//   out_valid, out_data and out_last are unchanged until the consumer takes them.
//  Latency: 1 cycle; accepted element appears registered on out_data next cycle.
//   Full throughput is 1 element per cycle when out_ready stays high.
//  Arithmetic: x = in_data sign-extended to 2*SIZE.
//   in_data[SIZE-1]==1: out_data = x (negative passes with slope alpha relative to positive).
//   Otherwise: out_data = x << shift; zero maps to 0. With shift<=SIZE no overflow is possible.
//  out_last=1 exactly with the result of the final element; 0 otherwise.
//  count increments per accept and saturates at latched_count; cleared on start/abort.
//  Simultaneous output handshake and new accept in same cycle: register reloads, no bubble.
// TESTING (SIZE=8, CNT_W=10)
//  1 start count=3 shift=4; in 0x05,0xFB,0x00 all cycles ready
//    -> out 0x0050, 0xFFFB, 0x0000 on consecutive cycles; last on 3rd; done 1 cycle later.
//  2 shift=15 (clamped to 8); in 0x7F -> out 0x7F00; in 0x80 -> out 0xFF80.
//  3 count=4; out_ready low 3 cycles after first output
//    -> in_ready=0 during stall, out_data held; no loss, no duplicate, 4 outputs total.
//  4 start count=0 -> busy stays 0, done pulses once; start during RUN -> ignored, count unchanged.
//  5 abort after 2 of 5 accepted -> IDLE next cycle, out_valid=0, count=0, done never asserts;
//    new start then runs cleanly.
//  6 rst_n low mid-RUN (async, off-edge) -> all outputs to reset values immediately.
//    Random back-to-back layers vs. reference model: outputs match.

Source files
------------

// File: rtl/leaky_relu_act_sched_if.sv
// Streaming handshake bundle for the leaky-ReLU activation stage.
// The DUT uses the slave side. The producer/consumer (MAC array / next buffer) use master.
interface leaky_relu_act_sched_if #(
  parameter int SIZE = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [SIZE-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [2*SIZE-1:0]   out_data;
  logic                out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/leaky_relu_act_sched.sv
// Leaky-ReLU activation sequencer: runs one layer of elements through a
// single registered activation stage, tags the final result and pulses done.
module leaky_relu_act_sched #(
  parameter int SIZE    = 8,
  parameter int CNT_W   = 10,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               abort,
  leaky_relu_act_sched_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

  // Shift amount never exceeds SIZE, so it only needs to hold 0..SIZE.
  localparam int SHW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [2*SIZE-1:0] data;
  } out_reg_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat_count;
  logic [SHW-1:0]   lat_shift;
  logic [SHW-1:0]   shift_clamp;
  out_reg_t         oreg;
  logic             accept, out_fire, is_final, done_nxt, start_ok;
  logic [2*SIZE-1:0] x_ext, act;

  assign bus.in_ready  = (state == RUN) && (!oreg.vld || bus.out_ready);
  assign bus.out_valid = oreg.vld;
  assign bus.out_data  = oreg.data;
  assign bus.out_last  = oreg.last;
  assign busy          = (state != IDLE);

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = oreg.vld && bus.out_ready;
  assign is_final = (count == lat_count - 1'b1);
  assign start_ok = (state == IDLE) && start && !abort;

  // Clamp the configured shift to SIZE; larger shifts would overflow 2*SIZE.
  assign shift_clamp = (32'(cfg_shift) > SIZE) ? SHW'(SIZE) : SHW'(cfg_shift);

  // Activation: negatives pass unscaled, non-negatives scale up by 2^shift,
  // which is alpha = 2^-shift on the negative side relative to the positive.
  always_comb begin
    x_ext = {{SIZE{bus.in_data[SIZE-1]}}, bus.in_data};
    act   = bus.in_data[SIZE-1] ? x_ext : (x_ext << lat_shift);
  end

  // Next-state and done-pulse decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && cfg_count != '0) state_nxt = RUN;
          if (start && cfg_count == '0) done_nxt  = 1'b1;
        end
        RUN: begin
          if (accept && is_final) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (out_fire && oreg.last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Latch layer config on an honoured start; stable for the whole layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_count <= '0;
      lat_shift <= '0;
    end else if (start_ok && cfg_count != '0) begin
      lat_count <= cfg_count;
      lat_shift <= shift_clamp;
    end
  end

  // Accepted-element counter, saturating at the latched layer size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            count <= '0;
    else if (abort || start_ok)            count <= '0;
    else if (accept && count != lat_count) count <= count + 1'b1;
  end

  // Output register: reload on accept (even while draining, no bubble),
  // otherwise empty on consumer handshake; held under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg <= '0;
    end else if (abort) begin
      oreg.vld  <= 1'b0;
      oreg.last <= 1'b0;
    end else if (accept) begin
      oreg.vld  <= 1'b1;
      oreg.last <= is_final;
      oreg.data <= act;
    end else if (out_fire) begin
      oreg.vld  <= 1'b0;
      oreg.last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaky_relu_act_sched.sv
// Scoreboard bench for leaky_relu_act_sched: the driver pushes the expected
// result when an element is accepted, and the monitor pops it on output handshake.
module tb_leaky_relu_act_sched;
  localparam int SIZE = 8, CNT_W = 10, SHIFT_W = 4;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [CNT_W-1:0]   cfg_count = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic busy, done;
  logic [CNT_W-1:0] count;

  leaky_relu_act_sched_if #(.SIZE(SIZE)) bus();

  leaky_relu_act_sched #(.SIZE(SIZE), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_count(cfg_count),
    .cfg_shift(cfg_shift), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   n_tot = 0, n_pass = 0, done_cnt = 0, pops = 0;
  bit   done_pend = 0, rnd_en = 0;
  logic rdy_man = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference activation for the randomized layers.
  function automatic logic [15:0] ref_act(input logic [7:0] d, input int sh);
    int   s;
    logic [15:0] x;
    s = (sh > SIZE) ? SIZE : sh;
    x = {{8{d[7]}}, d};
    return d[7] ? x : (x << s);
  endfunction

  // Consumer ready: manual, or random during the random-layer phase.
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : rdy_man;
    end
  end

  // Monitor: checks each output handshake against the scoreboard, and done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_pend) chk("done_after_last", {31'd0, done}, 32'd1);
        done_pend = 0;
        if (done) done_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_out: got %h with empty scoreboard at %0t", bus.out_data, $time);
          end else begin
            e = sbq.pop_front();
            pops++;
            chk("out_data", {16'd0, bus.out_data}, {16'd0, e.d});
            chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
            if (bus.out_last) done_pend = 1;
          end
        end
      end
    end
  end

  task automatic do_start(input int cnt, input int sh);
    start = 1; cfg_count = CNT_W'(cnt); cfg_shift = SHIFT_W'(sh);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic push_elem(input logic [7:0] d, input logic [15:0] e, input logic last);
    bit ok = 0;
    bus.in_valid = 1; bus.in_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back('{d: e, last: last});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 200 && done_cnt == base; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("done_count", done_cnt - base, 32'd1);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("scoreboard_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    int base, n, sh;
    logic [7:0] d;
    bus.in_valid = 0; bus.in_data = '0;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n, sh, p0;
    logic [7:0] d;
    bus.in_valid = 0; bus.in_data = '0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_count", {22'd0, count}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: basic layer, shift 4
    base = done_cnt;
    do_start(3, 4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    push_elem(8'h05, 16'h0050, 0);
    push_elem(8'hFB, 16'hFFFB, 0);
    push_elem(8'h00, 16'h0000, 1);
    wait_done(base);

    // 2: shift clamped to SIZE
    base = done_cnt;
    do_start(3, 15);
    push_elem(8'h7F, 16'h7F00, 0);
    push_elem(8'h80, 16'hFF80, 0);
    push_elem(8'h01, 16'h0100, 1);
    wait_done(base);

    // 3: backpressure stall for 3 cycles after first output
    base = done_cnt; p0 = pops;
    do_start(4, 2);
    push_elem(8'h03, 16'h000C, 0);
    rdy_man = 0;
    bus.in_valid = 1; bus.in_data = 8'h81;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t3_stall_hold", {16'd0, bus.out_data}, 32'h000C);
      @(posedge clk); #1;
    end
    rdy_man = 1;
    push_elem(8'h81, 16'hFF81, 0);
    push_elem(8'h10, 16'h0040, 0);
    push_elem(8'hFF, 16'hFFFF, 1);
    wait_done(base);
    chk("t3_outputs", pops - p0, 32'd4);

    // 4: zero-count start, then start while running
    base = done_cnt;
    do_start(0, 3);
    chk("t4_zero_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_zero_done", done_cnt - base, 32'd1);
    base = done_cnt;
    do_start(2, 1);
    push_elem(8'h21, 16'h0042, 0);
    do_start(7, 0);
    chk("t4_restart_count", {22'd0, count}, 32'd1);
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    push_elem(8'h30, 16'h0060, 1);
    wait_done(base);

    // 5: abort after 2 of 5, then a clean layer
    base = done_cnt;
    do_start(5, 0);
    push_elem(8'h01, 16'h0001, 0);
    push_elem(8'h02, 16'h0002, 0);
    chk("t5_count_pre", {22'd0, count}, 32'd2);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_count", {22'd0, count}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - base, 32'd0);
    chk("t5_sb_empty", sbq.size(), 32'd0);
    base = done_cnt;
    do_start(1, 3);
    push_elem(8'h01, 16'h0008, 1);
    wait_done(base);

    // 6: async reset mid-layer with a held output
    do_start(4, 1);
    push_elem(8'h11, 16'h0022, 0);
    rdy_man = 0;
    #2;
    rst_n = 0;
    #1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_count", {22'd0, count}, 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
    sbq.delete();
    @(posedge clk); #3;
    rst_n = 1; rdy_man = 1;
    @(posedge clk); #1;

    // Random back-to-back layers with random backpressure
    rnd_en = 1;
    for (int l = 0; l < 4; l++) begin
      base = done_cnt;
      n  = $urandom_range(1, 6);
      sh = $urandom_range(0, 15);
      do_start(n, sh);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        push_elem(d, ref_act(d, sh), (k == n - 1));
      end
      wait_done(base);
    end
    rnd_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
